// File: rtl/cache_l1_nway.sv
// cache_l1_nway: N-way set-associative L1, true-LRU, write-through / write-allocate,
// blocking req/ack miss interface to L2. One word per line.
// Optional statistics counters are built when CACHE_STATS_EN is defined;
// otherwise hit_count / miss_count are tied to zero.
module cache_l1_nway #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int WAYS   = 2,
  parameter int SETS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_wren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              ready,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_q,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] MEM_RD = 2'd2;
  localparam logic [1:0] MEM_WR = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wren;
  logic [DATA_W-1:0] r_data;
  logic              r_hit;

  logic [SETS-1:0][WAYS-1:0]             valid;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tags;
  logic [SETS-1:0][WAYS-1:0][DATA_W-1:0] data;
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0]  age;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  r_tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way, victim, sel_way;
  logic              upd, touch, done, done_hit;
  logic [DATA_W-1:0] upd_data, done_q;

  assign idx   = r_addr[IDX_W-1:0];
  assign r_tag = r_addr[ADDR_W-1:IDX_W];
  assign ready = (state == IDLE);

  // Parallel tag match and victim choice (lowest invalid way, else the oldest).
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tags[idx][w] == r_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (age[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[idx][w]) victim = WAY_W'(w);
  end

  // Per-state array update / LRU touch enables and completion terms.
  // The set is untouched during MEM_RD, so the victim recomputed there matches LOOKUP.
  always_comb begin
    sel_way  = hit ? hit_way : victim;
    upd      = 1'b0;
    touch    = 1'b0;
    upd_data = r_data;
    done     = 1'b0;
    done_hit = 1'b0;
    done_q   = r_data;
    case (state)
      LOOKUP: begin
        if (r_wren) begin
          upd   = 1'b1;
          touch = 1'b1;
        end else if (hit) begin
          touch    = 1'b1;
          done     = 1'b1;
          done_hit = 1'b1;
          done_q   = data[idx][hit_way];
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          upd      = 1'b1;
          touch    = 1'b1;
          upd_data = mem_rdata;
          done     = 1'b1;
          done_q   = mem_rdata;
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          done     = 1'b1;
          done_hit = r_hit;
        end
      end
      default: ;
    endcase
  end

  // Line storage and LRU ages; touched way becomes age 0, younger ways age by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      tags  <= '0;
      data  <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else begin
      if (upd) begin
        valid[idx][sel_way] <= 1'b1;
        tags[idx][sel_way]  <= r_tag;
        data[idx][sel_way]  <= upd_data;
      end
      if (touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel_way)
            age[idx][w] <= '0;
          else if (age[idx][w] < age[idx][sel_way])
            age[idx][w] <= age[idx][w] + WAY_W'(1);
        end
      end
    end
  end

  // Control FSM, request capture, response pulse and L2 handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      r_addr     <= '0;
      r_wren     <= 1'b0;
      r_data     <= '0;
      r_hit      <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_q     <= '0;
      mem_req    <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= done;
      if (done) begin
        resp_hit <= done_hit;
        resp_q   <= done_q;
        mem_req  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_addr <= req_addr;
            r_wren <= req_wren;
            r_data <= req_data;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_hit <= hit;
          if (r_wren) begin
            state     <= MEM_WR;
            mem_req   <= 1'b1;
            mem_wren  <= 1'b1;
            mem_addr  <= r_addr;
            mem_wdata <= r_data;
          end else if (hit) begin
            state <= IDLE;
          end else begin
            state    <= MEM_RD;
            mem_req  <= 1'b1;
            mem_wren <= 1'b0;
            mem_addr <= r_addr;
          end
        end
        default: if (mem_ack) state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters, stepped on each completed request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (done) begin
      if (done_hit && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
      if (!done_hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_l1_nway.sv
// Self-checking bench for cache_l1_nway. Reference model keeps each set as a
// recency-ordered list of ways plus a flat L2 memory image.
module tb_cache_l1_nway;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int WAYS   = 2;
  localparam int SETS   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_wren;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              ready, resp_valid, resp_hit;
  logic [DATA_W-1:0] resp_q;
  logic              mem_req, mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       hit_count, miss_count;

  cache_l1_nway #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wren(req_wren), .req_addr(req_addr), .req_data(req_data),
    .ready(ready), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_q(resp_q),
    .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_hits, exp_miss;

  // reference model
  bit          m_valid [SETS][WAYS];
  logic [15:0] m_tag   [SETS][WAYS];
  logic [15:0] m_data  [SETS][WAYS];
  int          m_rec   [SETS][WAYS];   // position 0 = most recently used
  logic [15:0] l2mem   [128];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_rec[s][w]   = w;
      end
    exp_hits = 0;
    exp_miss = 0;
  endfunction

  function automatic int m_find(input logic [6:0] a);
    int s = int'(a) % SETS;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == 16'(int'(a) / SETS)) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w]) return w;
    return m_rec[s][WAYS-1];
  endfunction

  function automatic void m_touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < WAYS; i++) if (m_rec[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_rec[s][i] = m_rec[s][i-1];
    m_rec[s][0] = w;
  endfunction

  task automatic chk_stats(input string tag);
`ifdef CACHE_STATS_EN
    chk({tag, "_hits"}, hit_count, exp_hits);
    chk({tag, "_miss"}, miss_count, exp_miss);
`else
    chk({tag, "_hits"}, hit_count, 0);
    chk({tag, "_miss"}, miss_count, 0);
`endif
  endtask

  // One CPU request. Entered and left at a negedge with the DUT idle.
  task automatic do_req(input bit wr, input logic [6:0] a, input logic [15:0] d,
                        input int dly, input bit busy, input bit stray);
    int s, hw, w;
    bit eh;
    logic [15:0] eq;
    s  = int'(a) % SETS;
    hw = m_find(a);
    eh = (hw >= 0);
    chk("ready_idle", ready, 1);
    req_valid = 1'b1; req_wren = wr; req_addr = a; req_data = d;
    mem_ack = stray ? 1'($urandom) : 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (busy) begin
      req_addr = a ^ 7'h04;
      req_wren = 1'b0;
    end else req_valid = 1'b0;
    chk("ready_lookup", ready, 0);
    chk("resp_lookup", resp_valid, 0);
    mem_ack = stray ? 1'($urandom) : 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    if (!wr && eh) begin
      chk("hit_valid", resp_valid, 1);
      chk("hit_flag", resp_hit, 1);
      chk("hit_q", resp_q, m_data[s][hw]);
      chk("hit_nomem", mem_req, 0);
      m_touch(s, hw);
      exp_hits++;
    end else begin
      for (int i = 0; i <= dly; i++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_wren", mem_wren, wr);
        chk("mem_addr", mem_addr, a);
        if (wr) chk("mem_wdata", mem_wdata, d);
        chk("busy_ready", ready, 0);
        chk("no_resp", resp_valid, 0);
        mem_ack   = (i == dly);
        mem_rdata = (i == dly && !wr) ? l2mem[a] : 16'($urandom);
        @(negedge clk);
      end
      mem_ack = 1'b0;
      eq = wr ? d : l2mem[a];
      chk("miss_valid", resp_valid, 1);
      chk("resp_hit", resp_hit, wr ? eh : 1'b0);
      chk("resp_q", resp_q, eq);
      chk("req_drop", mem_req, 0);
      w = eh ? hw : m_victim(s);
      m_valid[s][w] = 1'b1;
      m_tag[s][w]   = 16'(int'(a) / SETS);
      m_data[s][w]  = eq;
      m_touch(s, w);
      if (wr) l2mem[a] = d;
      if (wr && eh) exp_hits++; else exp_miss++;
    end
    if (busy) begin
      req_valid = 1'b0;
      @(negedge clk);
      chk("busy_dropped", resp_valid, 0);
      chk("busy_nomem", mem_req, 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_wren = 1'b0; req_addr = '0; req_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 128; i++) l2mem[i] = 16'($urandom);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_q", resp_q, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk_stats("rst");

    // read miss then hit
    l2mem[7'h05] = 16'hBEEF;
    do_req(1'b0, 7'h05, 16'h0, 3, 1'b0, 1'b0);
    do_req(1'b0, 7'h05, 16'h0, 0, 1'b0, 1'b0);
    chk("s1_q", resp_q, 16'hBEEF);
    chk_stats("s1");

    // write-through, then read back
    do_req(1'b1, 7'h02, 16'h1234, 1, 1'b0, 1'b0);
    do_req(1'b0, 7'h02, 16'h0, 0, 1'b0, 1'b0);
    chk("wt_q", resp_q, 16'h1234);

    // LRU eviction in set 0
    do_reset();
    do_req(1'b0, 7'h00, 16'h0, 0, 1'b0, 1'b0);
    do_req(1'b0, 7'h02, 16'h0, 2, 1'b0, 1'b0);
    do_req(1'b0, 7'h00, 16'h0, 0, 1'b0, 1'b0);
    do_req(1'b0, 7'h04, 16'h0, 1, 1'b0, 1'b0);
    do_req(1'b0, 7'h00, 16'h0, 0, 1'b0, 1'b0);
    chk("lru_00_hit", resp_hit, 1);
    do_req(1'b0, 7'h02, 16'h0, 0, 1'b0, 1'b0);
    chk("lru_02_miss", resp_hit, 0);

    // busy drop: req_valid held through a miss
    do_req(1'b0, 7'h31, 16'h0, 3, 1'b1, 1'b0);

    // reset during MEM_RD
    req_valid = 1'b1; req_wren = 1'b0; req_addr = 7'h11;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_mem_req", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_req", mem_req, 0);
    chk("async_resp", resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_resp", resp_valid, 0);
      chk("post_rst_req", mem_req, 0);
    end
    do_req(1'b0, 7'h11, 16'h0, 0, 1'b0, 1'b0);
    chk("post_rst_miss", resp_hit, 0);

    // randomized traffic over a small address window to force evictions
    for (int n = 0; n < 200; n++)
      do_req(1'($urandom), 7'($urandom_range(0, 7)), 16'($urandom),
             int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 1'b1);
    chk_stats("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cache_l1_nway.md
# cache_l1_nway

Parametrised N-way set-associative L1 cache with true-LRU replacement, write-through/write-allocate policy and a request/acknowledge miss interface to L2. It succeeds the fixed 2-set/2-way L1 and sits between the processor datapath and the L2 cache. All CPU reads and writes go through it. Read misses and all writes are forwarded to L2 through a blocking handshake FSM.

## Interface
- ADDR_W, 7, word address width
- DATA_W, 16, word width; one word per line
- WAYS, 2, associativity (power of 2, ≥2)
- SETS, 2, number of sets (power of 2, ≥2); IDX_W = log2(SETS), TAG_W = ADDR_W − IDX_W
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request present
- req_wren  in  1  0 = read, 1 = write
- req_addr  in  ADDR_W  index = req_addr[IDX_W-1:0], tag = upper TAG_W bits
- req_data  in  DATA_W  write data
- ready  out  1  high only in IDLE; request accepted on an edge where req_valid & ready
- resp_valid  out  1  one-cycle completion pulse
- resp_hit  out  1  lookup result of the completed request
- resp_q  out  DATA_W  read data (reads) or written data (writes)
- mem_req  out  1  L2 request, held until acknowledged
- mem_wren  out  1  L2 write enable
- mem_addr  out  ADDR_W  L2 address
- mem_wdata  out  DATA_W  L2 write data
- mem_ack  in  1  L2 done; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  L2 read data
- hit_count, miss_count  out  16 each  statistics (see Configuration)

## Operation
- Storage per set/way: valid bit, tag, data word, LRU age (log2(WAYS) bits).
- The accepting edge registers addr, wren and data. State goes IDLE→LOOKUP.
- LOOKUP (one cycle) compares all valid ways in parallel. Exactly one match is a hit.
- Read hit: resp_valid=1, resp_hit=1, resp_q=data of the hit way. LRU is touched and the FSM returns to IDLE.
- Read miss: go to MEM_RD. The victim is the lowest-index invalid way, else the way with age WAYS−1.
- Write, hit or miss: the data word is written into the hit way or the victim way. Tag and valid are set and LRU is touched. Then go to MEM_WR.
- MEM_RD: mem_req=1, mem_wren=0, mem_addr=request address. On an edge with mem_ack:
  - the victim is filled with mem_rdata and LRU is touched;
  - resp_valid=1, resp_hit=0, resp_q=mem_rdata;
  - FSM returns to IDLE.
- MEM_WR: mem_req=1, mem_wren=1, mem_addr and mem_wdata come from the request. On an edge with mem_ack: resp_valid=1, resp_hit=lookup result, resp_q=written data, FSM returns to IDLE.
- LRU touch of way w:
  - every way of the set with age < age[w] increments;
  - age[w] becomes 0.
- Ages within a set always form a permutation of 0..WAYS−1.

## Timing
- Reset values:
  - ready=1, resp_valid=0, resp_hit=0, resp_q=0;
  - mem_req=0, mem_wren=0, mem_addr=0, mem_wdata=0, counters=0;
  - all valid bits 0, age[s][w]=w, state IDLE.
- Request accepted at edge n. A hit has resp_valid high between edges n+1 and n+2. ready is high again after edge n+1, so the next acceptance is no earlier than edge n+2.
- Miss and write path: mem_req rises after edge n+1 and stays high, with stable address and data, until the first edge where mem_ack=1. resp_valid pulses for the cycle after that edge. mem_req falls on the same edge.
- mem_ack may be high in the first mem_req cycle; this gives the minimum miss latency of 2 cycles after LOOKUP. mem_ack outside MEM_RD/MEM_WR is ignored.
- req_valid while ready=0 is ignored. It is neither queued nor acknowledged.
- Reset asserted mid-operation takes effect immediately:
  - mem_req and resp_valid drop without waiting for an edge;
  - the in-flight request is discarded with no response;
  - all lines are invalidated.
- The cache is never touched in MEM_RD until ack. A same-address request cannot arrive because the cache is blocking.

## Configuration
- CACHE_STATS_EN defined:
  - hit_count increments on every resp_valid with resp_hit=1;
  - miss_count increments on every resp_valid with resp_hit=0;
  - both saturate at 16'hFFFF and clear on reset.
- CACHE_STATS_EN undefined: the counters are not built and hit_count and miss_count are tied to 0.

## Test plan
Defaults apply; address 7'h05 maps to set 1, tag 6'h02.
- Read miss then hit: reset, read 7'h05, L2 acks after 3 cycles with 16'hBEEF. Required: mem_req=1, mem_wren=0, mem_addr=7'h05, then resp_hit=0, resp_q=16'hBEEF. Re-reading 7'h05 gives resp_hit=1, resp_q=16'hBEEF one cycle after LOOKUP, with no mem_req.
- Write-through: write 7'h02 = 16'h1234. Required: mem_wren=1, mem_addr=7'h02, mem_wdata=16'h1234, resp_hit=0. A following read of 7'h02 gives a hit with 16'h1234.
- LRU eviction in set 0:
  - read-miss 7'h00 then 7'h02, then re-read 7'h00 (hit);
  - read 7'h04 (miss) evicts 7'h02;
  - then 7'h00 hits and 7'h02 misses.
- Reset during MEM_RD with mem_req=1: mem_req drops to 0 asynchronously and no resp_valid is produced. A later read of the same address misses.
- Busy drop: req_valid held through a miss with a different address. Only the first request is answered, and ready=0 until the response.
- Statistics: run scenario 1 with CACHE_STATS_EN defined and require hit_count=1, miss_count=1. With the macro undefined, both stay 0.
